// File: rtl/jtframe_prot_lut.sv
// Downloadable challenge/response table for arcade copy-protection chips.
// A CPU write starts a linear scan; the lowest matching valid entry answers, else DEFAULT.
module jtframe_prot_lut #(
  parameter int            DW      = 8,
  parameter int            AW      = 5,
  parameter logic [DW-1:0] DEFAULT = '0
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            cs,
  input  logic            wr_n,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic            busy,
  output logic            hit,
  input  logic            prog_en,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [2*DW-1:0] prog_data,
  input  logic            prog_clr
);
  localparam int DEPTH = 2**AW;

  typedef enum logic { IDLE, SCAN } state_t;

  state_t             state_reg, state_next;
  logic [DW-1:0]      key_reg, key_next;
  logic [AW-1:0]      idx_reg, idx_next;
  logic [DW-1:0]      dout_reg, dout_next;
  logic               hit_reg, hit_next;
  logic               busy_reg, busy_next;

  logic [DEPTH-1:0]   valid;
  logic [DW-1:0]      keys [DEPTH];
  logic [DW-1:0]      vals [DEPTH];

  logic               cpu_wr;
  logic               entry_match;

  // Table storage: only the valid bits are reset; contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                valid <= '0;
    else if (prog_clr)         valid <= '0;
    else if (prog_en && prog_we) valid[prog_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (prog_en && prog_we) begin
      keys[prog_addr] <= prog_data[2*DW-1:DW];
      vals[prog_addr] <= prog_data[DW-1:0];
    end
  end

  assign cpu_wr      = cs && !wr_n;
  assign entry_match = valid[idx_reg] && (keys[idx_reg] == key_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
      dout_reg  <= DEFAULT;
      hit_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      idx_reg   <= idx_next;
      dout_reg  <= dout_next;
      hit_reg   <= hit_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    idx_next   = idx_reg;
    dout_next  = dout_reg;
    hit_next   = hit_reg;
    busy_next  = busy_reg;
    // The programming window overrides everything, independent of cen.
    if (prog_en) begin
      state_next = IDLE;
      busy_next  = 1'b0;
    end else if (cen) begin
      case (state_reg)
        IDLE: begin
          if (cpu_wr) begin
            state_next = SCAN;
            key_next   = din;
            idx_next   = '0;
            busy_next  = 1'b1;
          end
        end
        SCAN: begin
          if (cpu_wr) begin
            key_next = din;
            idx_next = '0;
          end else if (entry_match) begin
            state_next = IDLE;
            dout_next  = vals[idx_reg];
            hit_next   = 1'b1;
            busy_next  = 1'b0;
          end else if (idx_reg == AW'(DEPTH-1)) begin
            state_next = IDLE;
            dout_next  = DEFAULT;
            hit_next   = 1'b0;
            busy_next  = 1'b0;
          end else begin
            idx_next = idx_reg + AW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign dout = dout_reg;
  assign hit  = hit_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_jtframe_prot_lut.sv
// Randomised bench for jtframe_prot_lut against a table-search reference model.
module tb_jtframe_prot_lut;
  localparam int         DEPTH = 32;
  localparam logic [7:0] DEF   = 8'h00;

  logic        clk = 0, rst_n = 0, cen = 0, cs = 0, wr_n = 1;
  logic        prog_en = 0, prog_we = 0, prog_clr = 0;
  logic [7:0]  din = 0;
  logic [4:0]  prog_addr = 0;
  logic [15:0] prog_data = 0;
  logic [7:0]  dout;
  logic        busy, hit;

  int   checks = 0, errors = 0;
  bit   gaps = 0;
  bit         m_valid [DEPTH];
  logic [7:0] m_key   [DEPTH];
  logic [7:0] m_val   [DEPTH];
  logic [7:0] exp_dout = DEF;
  logic       exp_hit  = 0;

  always #5 clk = ~clk;

  jtframe_prot_lut dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs), .wr_n(wr_n), .din(din),
    .dout(dout), .busy(busy), .hit(hit), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_clr(prog_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic step(input bit c);
    cen = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    if (gaps) repeat ($urandom_range(0, 2)) step(0);
    step(1);
  endtask

  task automatic cpu_write(input logic [7:0] k);
    cs = 1; wr_n = 0; din = k;
    tick();
    cs = 0; wr_n = 1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
  endtask

  function automatic void model_lookup(input logic [7:0] k, output int lat,
                                       output logic [7:0] v, output logic h);
    lat = DEPTH; v = DEF; h = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_key[i] == k) begin
        lat = i + 1; v = m_val[i]; h = 1;
        break;
      end
    end
  endfunction

  task automatic prog_load(input int a, input logic [7:0] k, input logic [7:0] v);
    prog_en = 1; prog_we = 1; prog_addr = a[4:0]; prog_data = {k, v};
    step(1'($urandom_range(0, 1)));
    prog_we = 0; prog_en = 0;
    m_valid[a] = 1; m_key[a] = k; m_val[a] = v;
  endtask

  task automatic prog_clear(input bit with_we);
    prog_clr = 1; prog_en = with_we; prog_we = with_we;
    prog_addr = 5'd7; prog_data = 16'h3355;
    step(1'($urandom_range(0, 1)));
    prog_clr = 0; prog_en = 0; prog_we = 0;
    model_clear();
  endtask

  // Full lookup: write the challenge, count cen ticks until busy drops, check result.
  task automatic lookup(input logic [7:0] k, input string tag);
    int lat, n;
    logic [7:0] v;
    logic h;
    model_lookup(k, lat, v, h);
    cpu_write(k);
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (busy && n < DEPTH + 4) begin
      chk({tag, "_hold"}, {hit, dout}, {exp_hit, exp_dout});
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_dout"}, dout, v);
    chk({tag, "_hit"}, hit, h);
    chk({tag, "_idle"}, busy, 0);
    $display("lookup %s key=%02h dout=%02h hit=%0d ticks=%0d", tag, k, dout, hit, n);
    exp_dout = v; exp_hit = h;
  endtask

  initial begin
    model_clear();
    repeat (3) step(1);
    chk("por_dout", dout, DEF);
    chk("por_busy", busy, 0);
    chk("por_hit", hit, 0);
    rst_n = 1;
    step(1);

    // Give dout/hit non-reset values, then reset in the middle of a scan.
    prog_load(0, 8'h24, 8'h1d);
    lookup(8'h24, "pre");
    cpu_write(8'h77);
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    chk("arst_dout", dout, DEF);
    chk("arst_busy", busy, 0);
    chk("arst_hit", hit, 0);
    step(1);
    rst_n = 1;
    model_clear();
    exp_dout = DEF; exp_hit = 0;
    step(1);
    chk("rel_busy", busy, 0);
    lookup(8'h24, "empty");

    prog_load(0, 8'h24, 8'h1d);
    prog_load(31, 8'h25, 8'h04);
    for (int g = 0; g < 2; g++) begin
      gaps = (g == 1);
      lookup(8'h24, "first");
      lookup(8'h25, "last");
      lookup(8'h77, "miss");
    end
    gaps = 0;

    // Restart: the 0x25 lookup is discarded and 0x04 never appears.
    cpu_write(8'h25);
    repeat (4) begin
      tick();
      chk("rst_scan_busy", busy, 1);
      chk("rst_scan_hold", {hit, dout}, {exp_hit, exp_dout});
    end
    lookup(8'h24, "restart");

    prog_load(3, 8'h60, 8'hf7);
    prog_load(9, 8'h60, 8'haa);
    lookup(8'h60, "dup");

    // prog_en aborts a scan and blocks CPU writes.
    cpu_write(8'h77);
    repeat (3) tick();
    prog_en = 1;
    step(1);
    chk("abort_busy", busy, 0);
    chk("abort_hold", {hit, dout}, {exp_hit, exp_dout});
    cs = 1; wr_n = 0; din = 8'h24;
    repeat (3) step(1);
    cs = 0; wr_n = 1; prog_en = 0;
    repeat (2) step(1);
    chk("ign_busy", busy, 0);
    chk("ign_hold", {hit, dout}, {exp_hit, exp_dout});

    prog_clear(0);
    lookup(8'h24, "clr");
    prog_load(2, 8'h55, 8'h66);
    prog_clear(1);
    lookup(8'h55, "clr_we");
    lookup(8'h33, "clr_we2");

    // Randomised mix of loads, clears and lookups.
    for (int r = 0; r < 60; r++) begin
      int sel;
      sel = $urandom_range(0, 99);
      gaps = $urandom_range(0, 1) == 1;
      if (sel < 35)
        prog_load($urandom_range(0, DEPTH-1), 8'h40 + 8'($urandom_range(0, 15)), 8'($urandom));
      else if (sel < 38)
        prog_clear(1'($urandom_range(0, 1)));
      else if (sel < 85)
        lookup(8'h40 + 8'($urandom_range(0, 15)), "rnd");
      else
        lookup(8'($urandom), "rndany");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
